// File: rtl/ifetch_axi_reader.sv
// AXI4 read-master instruction fetch: one INCR burst per PC, beats collected into a
// bundle handed to decode with valid/ready, plus a one-cycle pc_advance pulse per bundle.
module ifetch_axi_reader #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W-1:0]           pc_addr,
    input  logic                        redirect,
    output logic [ADDR_W-1:0]           araddr,
    output logic [7:0]                  arlen,
    output logic [2:0]                  arsize,
    output logic [1:0]                  arburst,
    output logic                        arvalid,
    input  logic                        arready,
    input  logic [DATA_W-1:0]           rdata,
    input  logic [1:0]                  rresp,
    input  logic                        rlast,
    input  logic                        rvalid,
    output logic                        rready,
    output logic                        ibuf_valid,
    input  logic                        ibuf_ready,
    output logic [ADDR_W-1:0]           ibuf_pc,
    output logic [BURST_LEN*DATA_W-1:0] ibuf_instr,
    output logic                        ibuf_err,
    output logic                        pc_advance,
    output logic [1:0]                  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] BL_C   = CW'(BURST_LEN);
    localparam logic [CW-1:0] LAST_C = CW'(BURST_LEN - 1);

    state_t                        state_q, state_d;
    logic [ADDR_W-1:0]             araddr_q, araddr_d;
    logic                          arvalid_q, arvalid_d;
    logic                          rready_q, rready_d;
    logic                          ibuf_valid_q, ibuf_valid_d;
    logic [ADDR_W-1:0]             ibuf_pc_q, ibuf_pc_d;
    logic [BURST_LEN*DATA_W-1:0]   instr_q, instr_d;
    logic                          err_q, err_d;
    logic                          pc_adv_q, pc_adv_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          redir_q, redir_d;
    logic                          beat;

    // Handshakes: a transfer happens on the clock edge where valid and ready are both 1;
    // a master holds valid and its payload stable until that edge.
    assign beat = rvalid & rready_q;

    always_comb begin
        state_d      = state_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        ibuf_valid_d = ibuf_valid_q;
        ibuf_pc_d    = ibuf_pc_q;
        instr_d      = instr_q;
        err_d        = err_q;
        pc_adv_d     = 1'b0;
        cnt_d        = cnt_q;
        redir_d      = redir_q;

        if (ibuf_valid_q && ibuf_ready) ibuf_valid_d = 1'b0;
        if (redirect) ibuf_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!ibuf_valid_q && !redirect) begin
                    araddr_d  = {pc_addr[ADDR_W-1:2], 2'b00};
                    arvalid_d = 1'b1;
                    redir_d   = 1'b0;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (redirect) redir_d = 1'b1;
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    instr_d   = '0;
                    ibuf_pc_d = araddr_q;
                    redir_d   = 1'b0;
                    state_d   = (redir_q || redirect) ? DRAIN : DATA;
                end
            end
            DATA: begin
                if (redirect) begin
                    // A beat taken alongside redirect is dropped; if it ends the burst we are done.
                    if (beat && rlast) begin
                        rready_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (beat) begin
                    for (int k = 0; k < BURST_LEN; k++) begin
                        if (cnt_q == CW'(k)) instr_d[k*DATA_W +: DATA_W] = rdata;
                    end
                    if (cnt_q != BL_C) cnt_d = cnt_q + CW'(1);
                    if (rresp != 2'b00 || cnt_q == BL_C) err_d = 1'b1;
                    if (rlast) begin
                        if (cnt_q != LAST_C) err_d = 1'b1;
                        rready_d     = 1'b0;
                        ibuf_valid_d = 1'b1;
                        pc_adv_d     = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (beat && rlast) begin
                    rready_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            ibuf_valid_q <= 1'b0;
            ibuf_pc_q    <= '0;
            instr_q      <= '0;
            err_q        <= 1'b0;
            pc_adv_q     <= 1'b0;
            cnt_q        <= '0;
            redir_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            ibuf_valid_q <= ibuf_valid_d;
            ibuf_pc_q    <= ibuf_pc_d;
            instr_q      <= instr_d;
            err_q        <= err_d;
            pc_adv_q     <= pc_adv_d;
            cnt_q        <= cnt_d;
            redir_q      <= redir_d;
        end
    end

    assign araddr     = araddr_q;
    assign arlen      = 8'(BURST_LEN - 1);
    assign arsize     = 3'b010;
    assign arburst    = 2'b01;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign ibuf_valid = ibuf_valid_q;
    assign ibuf_pc    = ibuf_pc_q;
    assign ibuf_instr = instr_q;
    assign ibuf_err   = err_q;
    assign pc_advance = pc_adv_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ifetch_axi_reader.sv
// Directed bench for ifetch_axi_reader: transaction-level bundle model, scoreboard and
// per-cycle protocol monitor, plus literal expectations for each scenario.
module tb_ifetch_axi_reader;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BL = 2;

  logic clk, rst;
  logic [AW-1:0] pc_addr;
  logic redirect;
  logic [AW-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid, arready;
  logic [DW-1:0] rdata;
  logic [1:0] rresp;
  logic rlast, rvalid, rready;
  logic ibuf_valid, ibuf_ready;
  logic [AW-1:0] ibuf_pc;
  logic [BL*DW-1:0] ibuf_instr;
  logic ibuf_err, pc_advance;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] exp_ar_q[$];
  logic [AW-1:0] exp_pc_q[$];
  logic [BL*DW-1:0] exp_instr_q[$];
  logic exp_err_q[$];

  logic [DW-1:0] beat_d[4];
  logic [1:0] beat_r[4];
  logic rbusy;

  ifetch_axi_reader #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .redirect(redirect),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .ibuf_valid(ibuf_valid), .ibuf_ready(ibuf_ready), .ibuf_pc(ibuf_pc),
    .ibuf_instr(ibuf_instr), .ibuf_err(ibuf_err), .pc_advance(pc_advance),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // bundle model: slot k holds beat k for k < BL; error on any bad resp or wrong beat count
  function automatic void model(input int n, output logic [BL*DW-1:0] instr, output logic err);
    instr = '0;
    err = (n != BL);
    for (int i = 0; i < n; i++) begin
      if (i < BL) instr[i*DW +: DW] = beat_d[i];
      if (beat_r[i] != 2'b00) err = 1'b1;
    end
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_arvalid();
    int n = 0;
    while (!arvalid && n < 20) begin
      tick();
      n++;
    end
    chk("arvalid_timeout", arvalid, 1);
  endtask

  task automatic start_ar(input logic [AW-1:0] exp_addr, input int ar_wait);
    wait_arvalid();
    exp_ar_q.push_back(exp_addr);
    arready = 0;
    for (int i = 0; i < ar_wait; i++) begin
      tick();
      chk("ar_wait_valid", arvalid, 1);
      chk("ar_wait_addr", araddr, exp_addr);
    end
    arready = 1;
    tick();
    arready = 0;
    chk("rready_rise", rready, 1);
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [1:0] r, input logic l);
    rvalid = 1; rdata = d; rresp = r; rlast = l;
    tick();
    rvalid = 0; rresp = 2'b00; rlast = 0;
  endtask

  task automatic fetch(input logic [AW-1:0] exp_addr, input int ar_wait, input int n);
    logic [BL*DW-1:0] mi;
    logic me;
    start_ar(exp_addr, ar_wait);
    model(n, mi, me);
    exp_pc_q.push_back(exp_addr);
    exp_instr_q.push_back(mi);
    exp_err_q.push_back(me);
    for (int i = 0; i < n; i++) send_beat(beat_d[i], beat_r[i], i == n - 1);
    chk("bundle_latency", ibuf_valid, 1);
    chk("pc_advance_latency", pc_advance, 1);
    chk("rready_fall", rready, 0);
  endtask

  task automatic accept(input logic [AW-1:0] next_pc, input int hold);
    pc_addr = next_pc;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_no_ar", arvalid, 0);
      chk("hold_valid", ibuf_valid, 1);
    end
    ibuf_ready = 1;
    tick();
    ibuf_ready = 0;
    chk("accept_clears", ibuf_valid, 0);
    chk("accept_no_ar_yet", arvalid, 0);
    tick();
    chk("ar_after_accept", arvalid, 1);
    chk("ar_after_accept_addr", araddr, {next_pc[AW-1:2], 2'b00});
  endtask

  task automatic clear_beats();
    for (int i = 0; i < 4; i++) begin
      beat_d[i] = '0;
      beat_r[i] = 2'b00;
    end
  endtask

  // scoreboard / protocol monitor
  initial begin
    logic p_arv, p_arr, p_iv, p_ir, p_red, p_err;
    logic [AW-1:0] p_araddr, p_ipc;
    logic [BL*DW-1:0] p_instr;
    p_arv = 0; p_arr = 0; p_iv = 0; p_ir = 0; p_red = 0; p_err = 0;
    p_araddr = '0; p_ipc = '0; p_instr = '0;
    rbusy = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_arv = 0; p_iv = 0; rbusy = 0;
      end else begin
        if (p_arv && !p_arr) begin
          chk("mon_ar_hold_valid", arvalid, 1);
          chk("mon_ar_hold_addr", araddr, p_araddr);
        end
        if (p_iv && !p_ir && !p_red) begin
          chk("mon_ibuf_hold_valid", ibuf_valid, 1);
          chk("mon_ibuf_hold_pc", ibuf_pc, p_ipc);
          chk("mon_ibuf_hold_instr", ibuf_instr, p_instr);
          chk("mon_ibuf_hold_err", ibuf_err, p_err);
        end
        if (pc_advance || (ibuf_valid && !p_iv))
          chk("mon_pc_advance_pulse", pc_advance, ibuf_valid && !p_iv);
        if (arvalid) chk("mon_no_ar_while_busy", arvalid & rbusy, 0);
        if (arvalid && arready) begin
          if (exp_ar_q.size() == 0) chk("mon_ar_unexpected", arvalid, 0);
          else chk("mon_ar_addr", araddr, exp_ar_q.pop_front());
          chk("mon_arlen", arlen, BL - 1);
          chk("mon_arsize", arsize, 3'b010);
          chk("mon_arburst", arburst, 2'b01);
          rbusy = 1;
        end
        if (rvalid && rready && rlast) rbusy = 0;
        if (ibuf_valid && ibuf_ready) begin
          if (exp_pc_q.size() == 0) begin
            chk("mon_bundle_unexpected", ibuf_valid, 0);
          end else begin
            chk("mon_bundle_pc", ibuf_pc, exp_pc_q.pop_front());
            chk("mon_bundle_instr", ibuf_instr, exp_instr_q.pop_front());
            chk("mon_bundle_err", ibuf_err, exp_err_q.pop_front());
          end
        end
        p_arv = arvalid; p_arr = arready; p_araddr = araddr;
        p_iv = ibuf_valid; p_ir = ibuf_ready; p_red = redirect;
        p_ipc = ibuf_pc; p_instr = ibuf_instr; p_err = ibuf_err;
      end
    end
  end

  // directed scenarios
  initial begin
    rst = 1; pc_addr = 32'h100; redirect = 0; arready = 0;
    rdata = '0; rresp = 2'b00; rlast = 0; rvalid = 0; ibuf_ready = 0;
    clear_beats();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_ibuf_valid", ibuf_valid, 0);
    chk("rst_ibuf_err", ibuf_err, 0);
    chk("rst_pc_advance", pc_advance, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_ibuf_pc", ibuf_pc, 0);
    chk("rst_ibuf_instr", ibuf_instr, 0);
    chk("rst_state", dbg_state, 0);
    rst = 0;
    tick();
    chk("first_ar_latency", arvalid, 1);
    chk("first_araddr", araddr, 32'h100);
    chk("arlen_const", arlen, 8'd1);

    // basic two-beat fetch, then a held bundle
    beat_d[0] = 32'hAAAA0001; beat_d[1] = 32'hAAAA0002;
    fetch(32'h100, 0, 2);
    chk("t1_pc", ibuf_pc, 32'h100);
    chk("t1_instr", ibuf_instr, 64'hAAAA0002_AAAA0001);
    chk("t1_err", ibuf_err, 0);
    tick();
    chk("t1_pulse_once", pc_advance, 0);
    accept(32'h143, 4);

    // AR stalled for 5 cycles
    clear_beats();
    beat_d[0] = 32'hBBBB0001; beat_d[1] = 32'hBBBB0002;
    fetch(32'h140, 5, 2);
    chk("t2_instr", ibuf_instr, 64'hBBBB0002_BBBB0001);
    accept(32'h180, 0);

    // redirect after the first beat
    start_ar(32'h180, 0);
    send_beat(32'hCCCC0001, 2'b00, 0);
    redirect = 1; pc_addr = 32'h200;
    tick();
    redirect = 0;
    chk("t4_state_drain", dbg_state, 3);
    send_beat(32'hCCCC0002, 2'b00, 1);
    chk("t4_no_valid", ibuf_valid, 0);
    chk("t4_no_advance", pc_advance, 0);
    chk("t4_rready_fall", rready, 0);
    tick();
    chk("t4_next_ar", arvalid, 1);
    chk("t4_next_addr", araddr, 32'h200);

    // error response on second beat
    clear_beats();
    beat_d[0] = 32'hDDDD0001; beat_d[1] = 32'hDDDD0002; beat_r[1] = 2'b10;
    fetch(32'h200, 0, 2);
    chk("t5a_err", ibuf_err, 1);
    chk("t5a_instr", ibuf_instr, 64'hDDDD0002_DDDD0001);
    accept(32'h300, 0);

    // early rlast
    clear_beats();
    beat_d[0] = 32'hEEEE0001;
    fetch(32'h300, 0, 1);
    chk("t5b_err", ibuf_err, 1);
    chk("t5b_instr", ibuf_instr, 64'h00000000_EEEE0001);
    accept(32'h400, 0);

    // extra beat beyond the burst length
    clear_beats();
    beat_d[0] = 32'h11110001; beat_d[1] = 32'h11110002; beat_d[2] = 32'h11110003;
    fetch(32'h400, 0, 3);
    chk("t8_err", ibuf_err, 1);
    chk("t8_instr", ibuf_instr, 64'h11110002_11110001);
    accept(32'h500, 0);

    // redirect while AR is waiting
    wait_arvalid();
    exp_ar_q.push_back(32'h500);
    redirect = 1; pc_addr = 32'h600;
    tick();
    redirect = 0;
    chk("t7_ar_held", arvalid, 1);
    arready = 1;
    tick();
    arready = 0;
    chk("t7_state_drain", dbg_state, 3);
    chk("t7_rready", rready, 1);
    send_beat(32'h22220001, 2'b00, 0);
    send_beat(32'h22220002, 2'b00, 1);
    chk("t7_no_valid", ibuf_valid, 0);
    chk("t7_rready_fall", rready, 0);
    tick();
    chk("t7_next_addr", araddr, 32'h600);

    // asynchronous reset in the middle of a burst
    start_ar(32'h600, 0);
    send_beat(32'h33330001, 2'b00, 0);
    #2 rst = 1;
    #1;
    chk("t6_arvalid", arvalid, 0);
    chk("t6_rready", rready, 0);
    chk("t6_ibuf_valid", ibuf_valid, 0);
    chk("t6_araddr", araddr, 0);
    chk("t6_ibuf_instr", ibuf_instr, 0);
    chk("t6_state", dbg_state, 0);
    @(posedge clk);
    #1;
    rst = 0; pc_addr = 32'h700;
    tick();
    chk("t6_restart_ar", arvalid, 1);
    chk("t6_restart_addr", araddr, 32'h700);
    clear_beats();
    beat_d[0] = 32'h44440001; beat_d[1] = 32'h44440002;
    fetch(32'h700, 0, 2);
    chk("t6_instr", ibuf_instr, 64'h44440002_44440001);
    accept(32'h800, 0);

    tick();
    chk("end_ar_queue_empty", exp_ar_q.size(), 0);
    chk("end_bundle_queue_empty", exp_pc_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
